// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants and helpers for the multiply/divide unit.
//   - mduOp encodings (must match the decoder's md/mt control encoding)
//   - is_long_op(): ops that occupy the unit for several cycles
//   - is_div_op():  ops that use the divide latency
// Optional feature macro: MDU_MADD_EN (adds madd/maddu as long ops).
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;

  // Multi-cycle ops that raise busy when accepted.
  function automatic logic is_long_op(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_long_op = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    is_long_op = 1'b1;
`endif
      default:                                is_long_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    is_div_op = (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage <-> multiply/divide unit bundle.
//   master (pipeline): drives start, mduOp, req, d1, d2; reads busy, hi, lo
//   slave  (mdu):      reads the controls/operands; drives busy, hi, lo
interface mdu_if;
  logic        start;
  logic [3:0]  mduOp;
  logic        req;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mduOp, req, d1, d2, input busy, hi, lo);
  modport slave  (input start, mduOp, req, d1, d2, output busy, hi, lo);
endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: combinational result datapath of the multiply/divide unit.
//   op_i       latched operation
//   a_i, b_i   latched rs / rt operands
//   acc_i      current {HI,LO}; accumulator for madd/maddu, passthrough otherwise
//   res_o      64-bit result {HI,LO}
//   div_zero_o divide op with zero divisor (commit must leave HI/LO alone)
// Optional feature macro: MDU_MADD_EN (madd/maddu accumulate path).
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [63:0] acc_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] safe_b_s;
  logic [31:0] safe_mag_b_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] sq_mag_s;
  logic [31:0] sr_mag_s;
  logic [31:0] sq_s;
  logic [31:0] sr_s;

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide via magnitudes; 0x80000000 has magnitude 0x80000000 as unsigned,
  // which also yields the required 0x80000000 / -1 = 0x80000000, remainder 0.
  assign mag_a_s      = a_i[31] ? (32'd0 - a_i) : a_i;
  assign mag_b_s      = b_i[31] ? (32'd0 - b_i) : b_i;
  // Zero divisors are replaced so the dividers never see 0; the result is discarded.
  assign safe_b_s     = (b_i == 32'd0) ? 32'd1 : b_i;
  assign safe_mag_b_s = (b_i == 32'd0) ? 32'd1 : mag_b_s;

  assign uq_s     = a_i / safe_b_s;
  assign ur_s     = a_i % safe_b_s;
  assign sq_mag_s = mag_a_s / safe_mag_b_s;
  assign sr_mag_s = mag_a_s % safe_mag_b_s;
  assign sq_s     = (a_i[31] ^ b_i[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
  assign sr_s     = a_i[31] ? (32'd0 - sr_mag_s) : sr_mag_s;

  assign div_zero_o = is_div_op(op_i) && (b_i == 32'd0);

  // Result select by operation.
  always_comb begin
    res_o = acc_i;
    case (op_i)
      MDU_MULT:  res_o = prod_s;
      MDU_MULTU: res_o = prod_u;
      MDU_DIV:   res_o = {sr_s, sq_s};
      MDU_DIVU:  res_o = {ur_s, uq_s};
`ifdef MDU_MADD_EN
      MDU_MADD:  res_o = acc_i + prod_s;
      MDU_MADDU: res_o = acc_i + prod_u;
`endif
      default:   res_o = acc_i;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit holding HI/LO.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; aborts any operation in flight
//   bus    mdu_if.slave: start/mduOp/req/d1/d2 in, busy/hi/lo out
// Long ops hold busy for MULT_CYCLES (mult/multu/madd/maddu) or DIV_CYCLES
// (div/divu) cycles and commit HI/LO as busy falls; mthi/mtlo write in one cycle.
// Optional feature macro: MDU_MADD_EN (mduOp 7/8 = madd/maddu).
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [3:0] MULT_N  = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N   = 4'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;

  logic        issue_s;
  logic        accept_s;
  logic        mt_s;
  logic [63:0] res_s;
  logic        div_zero_s;

  // req flushes the E-stage instruction, so it blocks issue for this cycle only.
  assign issue_s  = bus.start & ~bus.req & ~busy_q;
  assign accept_s = issue_s & is_long_op(bus.mduOp);
  assign mt_s     = issue_s & ((bus.mduOp == MDU_MTHI) || (bus.mduOp == MDU_MTLO));

  mdu_calc u_calc (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .acc_i      ({hi_q, lo_q}),
    .res_o      (res_s),
    .div_zero_o (div_zero_s)
  );

  // Next-state: accept / move-to / count down and commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          cnt_d   = is_div_op(bus.mduOp) ? DIV_N : MULT_N;
          op_d    = bus.mduOp;
          a_d     = bus.d1;
          b_d     = bus.d2;
        end else if (mt_s) begin
          if (bus.mduOp == MDU_MTHI) begin
            hi_d = bus.d1;
          end else begin
            lo_d = bus.d1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
          if (!div_zero_s) begin
            {hi_d, lo_d} = res_s;
          end else begin
            {hi_d, lo_d} = {hi_q, lo_q};
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
